// File: rtl/config_frame_loader_pkg.sv
// Shared types and constants for the configuration frame loader.
// Holds the frame FSM state encoding, the default sync word and the arbitration modes.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_LOCK  = 1;

  // Index of the highest set bit, or 0 when no bit is set.
  function automatic logic [4:0] highest_active(input logic [31:0] active);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (active[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/config_frame_loader_if.sv
// Bundle of the per-source configuration write ports.
// The bench drives the master side; the loader consumes the slave side.
interface config_frame_loader_if #(
  parameter int NUM_SOURCES = 3
);
  logic [NUM_SOURCES*32-1:0] SrcData;
  logic [NUM_SOURCES-1:0]    SrcStrobe;
  logic [NUM_SOURCES-1:0]    SrcActive;

  modport master (output SrcData, output SrcStrobe, output SrcActive);
  modport slave  (input  SrcData, input  SrcStrobe, input  SrcActive);
endinterface

// File: rtl/config_frame_loader_source_arbiter.sv
// Source arbiter: registered grant plus a zero-latency data/strobe mux on that grant.
// grant_changed is high in the cycle whose edge loads a different grant.
module config_source_arbiter
  import config_pkg::*;
#(
  parameter int NUM_SOURCES   = 3,
  parameter int PRIORITY_MODE = PRIO_FIXED,
  parameter int GW            = $clog2(NUM_SOURCES)
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [NUM_SOURCES*32-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]    src_strobe,
  input  logic [NUM_SOURCES-1:0]    src_active,
  output logic [GW-1:0]             grant,
  output logic                      grant_changed,
  output logic [31:0]               write_data,
  output logic                      write_strobe
);

  logic [GW-1:0] grant_r;
  logic [GW-1:0] next_grant_s;

  // Lock mode keeps the current owner while it stays active.
  always_comb begin
    next_grant_s = GW'(highest_active(32'(src_active)));
    if ((PRIORITY_MODE == PRIO_LOCK) && src_active[grant_r]) begin
      next_grant_s = grant_r;
    end else begin
      next_grant_s = GW'(highest_active(32'(src_active)));
    end
  end

  // Grant register, reloaded every cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      grant_r <= {GW{1'b0}};
    end else begin
      grant_r <= next_grant_s;
    end
  end

  // Output mux follows the registered grant only.
  always_comb begin
    write_data    = src_data[32*grant_r +: 32];
    write_strobe  = src_strobe[grant_r];
    grant_changed = (next_grant_s != grant_r);
  end

  assign grant = grant_r;

endmodule

// File: rtl/config_frame_loader.sv
// Multi-source configuration loader: arbitrates write ports and decodes the granted
// word stream into frame address, row select and long-frame strobe for the fabric.
module config_frame_loader
  import config_pkg::*;
#(
  parameter int          NUM_SOURCES     = 3,
  parameter int          NumberOfRows    = 20,
  parameter int          RowSelectWidth  = 5,
  parameter int          FrameBitsPerRow = 32,
  parameter int          desync_flag     = 20,
  parameter logic [31:0] SYNC_WORD       = DEFAULT_SYNC_WORD,
  parameter int          PRIORITY_MODE   = PRIO_FIXED
) (
  input  logic                             CLK,
  input  logic                             reset,
  config_frame_loader_if.slave             src,
  output logic [31:0]                      ConfigWriteData,
  output logic                             ConfigWriteStrobe,
  output logic [FrameBitsPerRow-1:0]       FrameAddressRegister,
  output logic                             LongFrameStrobe,
  output logic [RowSelectWidth-1:0]        RowSelect,
  output logic [$clog2(NUM_SOURCES)-1:0]   ActiveSource,
  output logic                             Busy,
  output logic [15:0]                      FrameCount,
  output logic                             AbortFlag
);

  localparam logic [RowSelectWidth-1:0] ROW_NONE  = {RowSelectWidth{1'b1}};
  localparam logic [RowSelectWidth-1:0] ROW_FIRST = RowSelectWidth'(NumberOfRows - 1);

  state_t state_r;
  logic   grant_changed_s;

  config_source_arbiter #(
    .NUM_SOURCES   (NUM_SOURCES),
    .PRIORITY_MODE (PRIORITY_MODE),
    .GW            ($clog2(NUM_SOURCES))
  ) u_arbiter (
    .CLK           (CLK),
    .reset         (reset),
    .src_data      (src.SrcData),
    .src_strobe    (src.SrcStrobe),
    .src_active    (src.SrcActive),
    .grant         (ActiveSource),
    .grant_changed (grant_changed_s),
    .write_data    (ConfigWriteData),
    .write_strobe  (ConfigWriteStrobe)
  );

  // Frame sequencing, counters and status flags; a grant change overrides any strobe.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r              <= IDLE;
      FrameAddressRegister <= {FrameBitsPerRow{1'b0}};
      RowSelect            <= ROW_NONE;
      LongFrameStrobe      <= 1'b0;
      Busy                 <= 1'b0;
      FrameCount           <= 16'd0;
      AbortFlag            <= 1'b0;
    end else begin
      LongFrameStrobe <= 1'b0;
      if (grant_changed_s) begin
        if (state_r != IDLE) begin
          AbortFlag <= 1'b1;
        end
        state_r   <= IDLE;
        RowSelect <= ROW_NONE;
        Busy      <= 1'b0;
      end else if (ConfigWriteStrobe) begin
        case (state_r)
          IDLE: begin
            if (ConfigWriteData == SYNC_WORD) begin
              state_r   <= ADDR;
              Busy      <= 1'b1;
              AbortFlag <= 1'b0;
            end
          end
          ADDR: begin
            if (ConfigWriteData[desync_flag]) begin
              state_r <= IDLE;
              Busy    <= 1'b0;
            end else begin
              state_r              <= DATA;
              FrameAddressRegister <= ConfigWriteData[FrameBitsPerRow-1:0];
              RowSelect            <= ROW_FIRST;
            end
          end
          DATA: begin
            if (RowSelect != {RowSelectWidth{1'b0}}) begin
              RowSelect <= RowSelect - RowSelectWidth'(1);
            end else begin
              // Last row: back to ADDR so a multi-frame session needs no new sync.
              RowSelect       <= ROW_NONE;
              LongFrameStrobe <= 1'b1;
              FrameCount      <= FrameCount + 16'd1;
              state_r         <= ADDR;
            end
          end
          default: begin
            state_r   <= IDLE;
            RowSelect <= ROW_NONE;
            Busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Bench for config_frame_loader: one fixed-priority and one lock-mode instance share
// the same source stimulus and are each compared with a session-level reference model.
module tb_config_frame_loader;
  import config_pkg::*;

  localparam int NS  = 3;
  localparam int NR  = 4;
  localparam int RSW = 5;
  localparam int GW  = 2;
  localparam logic [31:0]    SYNC  = 32'hFAB0_FAB1;
  localparam logic [RSW-1:0] RNONE = 5'h1F;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  config_frame_loader_if #(.NUM_SOURCES(NS)) bus ();

  logic [31:0]    cwd   [2];
  logic           cws   [2];
  logic [31:0]    far   [2];
  logic           lfs   [2];
  logic [RSW-1:0] rs    [2];
  logic [GW-1:0]  as_o  [2];
  logic           busy  [2];
  logic [15:0]    fc    [2];
  logic           abort [2];

  config_frame_loader #(
    .NUM_SOURCES(NS), .NumberOfRows(NR), .RowSelectWidth(RSW), .FrameBitsPerRow(32),
    .desync_flag(20), .SYNC_WORD(SYNC), .PRIORITY_MODE(PRIO_FIXED)
  ) dut0 (
    .CLK(CLK), .reset(reset), .src(bus),
    .ConfigWriteData(cwd[0]), .ConfigWriteStrobe(cws[0]), .FrameAddressRegister(far[0]),
    .LongFrameStrobe(lfs[0]), .RowSelect(rs[0]), .ActiveSource(as_o[0]), .Busy(busy[0]),
    .FrameCount(fc[0]), .AbortFlag(abort[0])
  );

  config_frame_loader #(
    .NUM_SOURCES(NS), .NumberOfRows(NR), .RowSelectWidth(RSW), .FrameBitsPerRow(32),
    .desync_flag(20), .SYNC_WORD(SYNC), .PRIORITY_MODE(PRIO_LOCK)
  ) dut1 (
    .CLK(CLK), .reset(reset), .src(bus),
    .ConfigWriteData(cwd[1]), .ConfigWriteStrobe(cws[1]), .FrameAddressRegister(far[1]),
    .LongFrameStrobe(lfs[1]), .RowSelect(rs[1]), .ActiveSource(as_o[1]), .Busy(busy[1]),
    .FrameCount(fc[1]), .AbortFlag(abort[1])
  );

  // Reference model: a session is "synced" once SYNC is seen; rows_left counts
  // remaining data words of the frame in progress (0 = waiting for an address).
  int          m_grant  [2];
  bit          m_synced [2];
  int          m_rows   [2];
  logic [31:0] m_far    [2];
  bit          m_lfs    [2];
  int          m_fc     [2];
  bit          m_abort  [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int pick_grant(int mode, int cur, logic [NS-1:0] act);
    if (mode == 1 && act[cur]) return cur;
    for (int i = NS - 1; i >= 0; i--) if (act[i]) return i;
    return 0;
  endfunction

  function automatic logic [RSW-1:0] exp_rs(int d);
    if (m_synced[d] && m_rows[d] > 0) return RSW'(m_rows[d] - 1);
    return RNONE;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_grant[d] = 0; m_synced[d] = 0; m_rows[d] = 0; m_far[d] = 32'h0;
      m_lfs[d] = 0; m_fc[d] = 0; m_abort[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [31:0] w;
      g = pick_grant(d, m_grant[d], bus.SrcActive);
      m_lfs[d] = 0;
      if (g != m_grant[d]) begin
        if (m_synced[d]) m_abort[d] = 1;
        m_synced[d] = 0;
        m_rows[d]   = 0;
        m_grant[d]  = g;
      end else if (bus.SrcStrobe[m_grant[d]]) begin
        w = bus.SrcData[32*m_grant[d] +: 32];
        if (!m_synced[d]) begin
          if (w == SYNC) begin m_synced[d] = 1; m_abort[d] = 0; end
        end else if (m_rows[d] == 0) begin
          if (w[20]) m_synced[d] = 0;
          else begin m_far[d] = w; m_rows[d] = NR; end
        end else begin
          m_rows[d]--;
          if (m_rows[d] == 0) begin m_lfs[d] = 1; m_fc[d] = (m_fc[d] + 1) % 65536; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive(int src, logic [31:0] w);
    bus.SrcData[32*src +: 32] = w;
    bus.SrcStrobe = '0;
    bus.SrcStrobe[src] = 1'b1;
  endtask

  task automatic send(int src, logic [31:0] w);
    drive(src, w);
    tick();
    bus.SrcStrobe = '0;
  endtask

  task automatic test_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (as_o[d] !== 2'd0 || busy[d] !== 1'b0 || rs[d] !== RNONE || far[d] !== 32'h0 ||
          lfs[d] !== 1'b0 || fc[d] !== 16'd0 || abort[d] !== 1'b0 || cws[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: as=%0d busy=%0b rs=%0h far=%0h lfs=%0b fc=%0d abort=%0b cws=%0b expected all reset values",
                 d, as_o[d], busy[d], rs[d], far[d], lfs[d], fc[d], abort[d], cws[d]);
      end
    end
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_frame();
    send(0, SYNC);
    send(0, 32'h0000_0005);
    for (int k = 0; k < NR; k++) begin
      drive(0, $urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (rs[d] !== RSW'(NR - 1 - k) || rs[d] !== exp_rs(d)) begin
          n_fail++;
          $display("FAIL frame_rowselect dut%0d word%0d: got %0d expected %0d", d, k, rs[d], NR - 1 - k);
        end
      end
      tick();
    end
    bus.SrcStrobe = '0;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (lfs[d] !== 1'b1 || fc[d] !== 16'd1 || rs[d] !== RNONE || busy[d] !== 1'b1 || far[d] !== 32'h5) begin
        n_fail++;
        $display("FAIL frame_end dut%0d: lfs=%0b fc=%0d rs=%0h busy=%0b far=%0h expected 1 1 1f 1 5",
                 d, lfs[d], fc[d], rs[d], busy[d], far[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (lfs[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_lfs_pulse dut%0d: got %0b expected 0", d, lfs[d]);
      end
    end
  endtask

  task automatic test_desync();
    send(0, 32'h0010_0000);
    send(0, SYNC);
    send(0, 32'h0010_0000);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (busy[d] !== 1'b0 || far[d] !== 32'h5 || rs[d] !== RNONE) begin
        n_fail++;
        $display("FAIL desync dut%0d: busy=%0b far=%0h rs=%0h expected 0 5 1f", d, busy[d], far[d], rs[d]);
      end
    end
  endtask

  task automatic test_abort();
    send(0, SYNC);
    send(0, 32'h0000_00A0);
    send(0, $urandom);
    send(0, $urandom);
    bus.SrcActive = 3'b100;
    drive(0, $urandom);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (as_o[d] !== 2'd2 || busy[d] !== 1'b0 || abort[d] !== 1'b1 || rs[d] !== RNONE || fc[d] !== 16'd1) begin
        n_fail++;
        $display("FAIL abort dut%0d: as=%0d busy=%0b abort=%0b rs=%0h fc=%0d expected 2 0 1 1f 1",
                 d, as_o[d], busy[d], abort[d], rs[d], fc[d]);
      end
    end
    drive(0, SYNC);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (cws[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ignored_strobe dut%0d: cws=%0b expected 0", d, cws[d]);
      end
    end
    tick();
    bus.SrcStrobe = '0;
    send(2, SYNC);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (abort[d] !== 1'b0 || busy[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_clear dut%0d: abort=%0b busy=%0b expected 0 1", d, abort[d], busy[d]);
      end
    end
    send(2, 32'h0010_0000);
  endtask

  task automatic test_lock();
    logic [GW-1:0] want [2];
    bus.SrcActive = 3'b010;
    tick();
    bus.SrcActive = 3'b110;
    tick();
    want[0] = 2'd2; want[1] = 2'd1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (as_o[d] !== want[d] || as_o[d] !== GW'(m_grant[d])) begin
        n_fail++;
        $display("FAIL lock_hold dut%0d: got %0d expected %0d", d, as_o[d], want[d]);
      end
    end
    bus.SrcActive = 3'b100;
    tick();
    n_tests++;
    if (as_o[1] !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_release dut1: got %0d expected 2", as_o[1]);
    end
    bus.SrcActive = 3'b000;
    tick();
  endtask

  task automatic test_ignore();
    send(0, 32'hDEAD_BEEF);
    for (int s = 1; s < NS; s++) begin
      drive(s, SYNC);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (cws[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_strobe dut%0d src%0d: cws=%0b expected 0", d, s, cws[d]);
        end
      end
      tick();
    end
    bus.SrcStrobe = '0;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (busy[d] !== 1'b0 || as_o[d] !== 2'd0) begin
        n_fail++;
        $display("FAIL ignore_state dut%0d: busy=%0b as=%0d expected 0 0", d, busy[d], as_o[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) bus.SrcActive = NS'($urandom_range(0, 7));
      for (int s = 0; s < NS; s++) begin
        case ($urandom_range(0, 3))
          0: bus.SrcData[32*s +: 32] = SYNC;
          1: bus.SrcData[32*s +: 32] = $urandom & 32'hFFEF_FFFF;
          default: bus.SrcData[32*s +: 32] = $urandom;
        endcase
      end
      bus.SrcStrobe = NS'($urandom_range(0, 7));
      #1;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (cwd[d] !== bus.SrcData[32*m_grant[d] +: 32] || cws[d] !== bus.SrcStrobe[m_grant[d]]) begin
          n_fail++;
          $display("FAIL random_mux dut%0d cycle%0d: data=%0h strobe=%0b expected %0h %0b", d, c,
                   cwd[d], cws[d], bus.SrcData[32*m_grant[d] +: 32], bus.SrcStrobe[m_grant[d]]);
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (as_o[d] !== GW'(m_grant[d]) || busy[d] !== m_synced[d] || rs[d] !== exp_rs(d) ||
            far[d] !== m_far[d] || lfs[d] !== m_lfs[d] || fc[d] !== 16'(m_fc[d]) || abort[d] !== m_abort[d]) begin
          n_fail++;
          $display("FAIL random_state dut%0d cycle%0d: as=%0d busy=%0b rs=%0h far=%0h lfs=%0b fc=%0d abort=%0b expected %0d %0b %0h %0h %0b %0d %0b",
                   d, c, as_o[d], busy[d], rs[d], far[d], lfs[d], fc[d], abort[d],
                   m_grant[d], m_synced[d], exp_rs(d), m_far[d], m_lfs[d], m_fc[d], m_abort[d]);
        end
      end
    end
    bus.SrcStrobe = '0;
  endtask

  task automatic test_reset_mid_data();
    bus.SrcActive = 3'b000;
    tick();
    send(0, 32'h0010_0000);
    send(0, SYNC);
    send(0, SYNC);
    send(0, SYNC);
    send(0, 32'h0000_0033);
    send(0, $urandom);
    send(0, $urandom);
    @(negedge CLK);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (as_o[d] !== 2'd0 || busy[d] !== 1'b0 || rs[d] !== RNONE || far[d] !== 32'h0 ||
          lfs[d] !== 1'b0 || fc[d] !== 16'd0 || abort[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: as=%0d busy=%0b rs=%0h far=%0h lfs=%0b fc=%0d abort=%0b expected reset values",
                 d, as_o[d], busy[d], rs[d], far[d], lfs[d], fc[d], abort[d]);
      end
    end
    model_reset();
    @(negedge CLK);
    reset = 1'b0;
    send(0, SYNC);
    send(0, 32'h0000_0077);
    for (int k = 0; k < NR; k++) send(0, $urandom);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (lfs[d] !== 1'b1 || fc[d] !== 16'd1 || far[d] !== 32'h77 || busy[d] !== m_synced[d]) begin
        n_fail++;
        $display("FAIL post_reset_frame dut%0d: lfs=%0b fc=%0d far=%0h busy=%0b expected 1 1 77 1",
                 d, lfs[d], fc[d], far[d], busy[d]);
      end
    end
  endtask

  initial begin
    bus.SrcData   = '0;
    bus.SrcStrobe = '0;
    bus.SrcActive = '0;
    model_reset();
    test_reset();
    test_frame();
    test_desync();
    test_abort();
    test_lock();
    test_ignore();
    test_random();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/config_frame_loader.md
# config_frame_loader

Multi-source configuration loader for the eFPGA fabric. It arbitrates `NUM_SOURCES` 32-bit configuration write ports, for example CPU, bitbang, UART or a future JTAG port. It decodes the granted word stream into frame address, row select and long-frame strobe for the tile columns. Compared with the fixed three-way mux plus frame FSM it supersedes, it adds a parametrised source count, a selectable arbitration mode, abort detection on source switch, and frame/status reporting.

## Interface
Parameters:
- `NUM_SOURCES`, 3: number of write ports. Index 0 is the default source; it is granted when no source is active.
- `NumberOfRows`, 20: data words per frame, one per fabric row.
- `RowSelectWidth`, 5: width of `RowSelect`. Must satisfy 2^`RowSelectWidth` > `NumberOfRows`.
- `FrameBitsPerRow`, 32: width of `FrameAddressRegister`.
- `desync_flag`, 20: bit position in the address word that requests desync.
- `SYNC_WORD`, 32'hFAB0_FAB1: word that starts a configuration session.
- `PRIORITY_MODE`, 0: 0 = fixed priority, highest active index wins. 1 = lock; the current grant is held while its `SrcActive` stays high.

Ports:
- `CLK`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `SrcData`  in  NUM_SOURCES*32  source i occupies bits [32i+31:32i].
- `SrcStrobe`  in  NUM_SOURCES  one-cycle write strobe per source.
- `SrcActive`  in  NUM_SOURCES  source requests ownership.
- `ConfigWriteData`  out  32  data of the granted source.
- `ConfigWriteStrobe`  out  1  strobe of the granted source.
- `FrameAddressRegister`  out  FrameBitsPerRow  last accepted address word.
- `LongFrameStrobe`  out  1  one-cycle pulse after the last row word.
- `RowSelect`  out  RowSelectWidth  row latching the current word. All-ones means no row.
- `ActiveSource`  out  $clog2(NUM_SOURCES)  registered grant index.
- `Busy`  out  1  FSM is not in IDLE.
- `FrameCount`  out  16  completed frames since reset. Wraps 0xFFFF→0.
- `AbortFlag`  out  1  sticky: a session was cut by a grant change.

## Operation
Arbitration:
- The grant register is updated every cycle.
- With no `SrcActive` bit set, the grant is 0.
- Mode 0: the grant is the highest index with `SrcActive` set.
- Mode 1: if `SrcActive[grant]` is 1, the grant is held. Otherwise the highest active index is granted, or 0 if none is active.
- `ConfigWriteData` and `ConfigWriteStrobe` are combinational selects on the registered grant.
- A strobe from any non-granted source is ignored and never reaches the FSM.

Grant change:
- The FSM is forced to IDLE in the same cycle the new grant registers.
- If the FSM was not in IDLE, `AbortFlag` is set to 1.
- `AbortFlag` clears when the next `SYNC_WORD` is accepted.

FSM states: IDLE, ADDR, DATA. Every transition requires a granted strobe.
- IDLE: data == `SYNC_WORD` → ADDR. Any other word is ignored.
- ADDR, data[`desync_flag`] = 1 → IDLE. `FrameAddressRegister` is unchanged.
- ADDR, data[`desync_flag`] = 0 → DATA. `FrameAddressRegister` <= data[FrameBitsPerRow-1:0]. `RowSelect` <= NumberOfRows-1.
- DATA, strobe with `RowSelect` ≠ 0: `RowSelect` decrements.
- DATA, strobe with `RowSelect` = 0: `RowSelect` <= all-ones, `LongFrameStrobe` <= 1 for one cycle, `FrameCount`++, → ADDR. This lets multi-frame sessions continue without a new sync.
- `RowSelect` is all-ones in IDLE and ADDR.
- A grant change and a strobe in the same cycle: the grant change wins and the strobe is dropped.
- `SYNC_WORD` received in ADDR or DATA is treated as ordinary data.

Reset values, applied asynchronously:
- grant = 0, FSM = IDLE.
- `FrameAddressRegister` = 0, `RowSelect` = all-ones.
- `LongFrameStrobe` = 0, `Busy` = 0, `FrameCount` = 0, `AbortFlag` = 0, `ActiveSource` = 0.

## Timing
- Grant latency: 1 cycle from a `SrcActive` change to `ActiveSource` and the output mux following it.
- Data path: `ConfigWriteData`/`ConfigWriteStrobe` have 0-cycle latency from the granted source.
- During a DATA strobe, `RowSelect` is the value the fabric uses to latch that word. It updates on the following edge.
- `LongFrameStrobe` and `FrameCount` update 1 cycle after the last row strobe.
- `Busy` is registered and reflects the state after the edge.
- Back-to-back strobes, one per cycle, are supported in all states.

## Structure
- Package `config_pkg`: state enum typedef (IDLE/ADDR/DATA), default `SYNC_WORD`, and the mode constants `PRIO_FIXED`=0 and `PRIO_LOCK`=1.
- Sub-module `config_source_arbiter`: grant register plus data/strobe mux. It outputs the grant index and a `grant_changed` pulse.
- The frame FSM, counters and flags stay in the top module.

## Test plan
- NumberOfRows=4, source 0: sync, addr 0x0000_0005, then 4 data words → `RowSelect` reads 3,2,1,0 at the strobes; `LongFrameStrobe` pulses 1 cycle after the 4th; `FrameCount`=1; state ADDR.
- Sync followed by 0x0010_0000 (bit 20 set) → IDLE; `FrameAddressRegister` keeps its prior value; `Busy`=0.
- Mode 0, source 0 in DATA after 2 rows, then `SrcActive[2]`=1 → `ActiveSource`=2 next cycle; FSM IDLE; `AbortFlag`=1; later source 0 strobes are ignored. A sync from source 2 clears `AbortFlag`.
- Mode 1, `SrcActive[1]` then `SrcActive[2]` both high → grant stays 1; dropping `SrcActive[1]` → grant 2 next cycle.
- Non-sync words 0xDEAD_BEEF in IDLE, and strobes on non-granted sources → no state change; `ConfigWriteStrobe` stays 0 for non-granted strobes.
- `reset` asserted mid-DATA between clock edges → all outputs at reset values immediately; after release, a full frame completes normally.
